// File: rtl/rv32_pkg.sv
// Shared RV32 constants: XLEN, M-extension funct3 codes and muldiv FSM state encoding.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic f3_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic f3_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative muldiv datapath: shift-add multiply or restoring divide step.
module muldiv_step #(
    parameter int N = 32
) (
    input  logic         mode,      // 0: multiply, 1: divide
    input  logic [N-1:0] acc,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] opnd,
    input  logic         cur_bit,
    output logic [N-1:0] acc_nxt,
    output logic [N-1:0] lo_nxt,
    output logic         qbit
);

    logic [N:0] sum;
    logic [N:0] shifted;
    logic [N:0] diff;
    logic       ge;

    always_comb begin
        sum     = {1'b0, acc} + (cur_bit ? {1'b0, opnd} : '0);
        shifted = {acc, cur_bit};
        diff    = shifted - {1'b0, opnd};
        ge      = ~diff[N];
        acc_nxt = '0;
        lo_nxt  = '0;
        qbit    = 1'b0;
        if (mode) begin
            // partial remainder stays below the divisor, so N+1 bits never overflow
            acc_nxt = ge ? diff[N-1:0] : shifted[N-1:0];
            lo_nxt  = {lo[N-2:0], 1'b0};
            qbit    = ge;
        end else begin
            acc_nxt = sum[N:1];
            lo_nxt  = {sum[0], lo[N-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (IDLE -> CALC -> FIX -> IDLE).
// Define MULDIV_FAST_MUL_EN to compute multiplies with one combinational multiplier and skip CALC.
//
//  state   | meaning
//  IDLE    | waiting for start, result held
//  CALC    | one multiply/divide bit per cycle, N cycles
//  FIX     | sign correction and word select, loads result
module muldiv_unit
    import rv32_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic [N-1:0]    acc, lo, opnd;
    logic            sa, sb, special, done_q;

    logic            in_sa, in_sb, in_div, div0, ovf, in_special, fast_mul, skip_calc;
    logic [N-1:0]    in_amag, in_bmag, special_word;
    logic [2*N-1:0]  init_al;

    logic [N-1:0]    step_acc, step_lo;
    logic            step_qbit, cur_bit;

    logic [2*N-1:0]  prod_s;
    logic [N-1:0]    mul_word, quo_word, rem_word, fix_word;

    // accept-side operand conditioning
    always_comb begin
        in_sa      = f3_signed_a(funct3) & rs1[N-1];
        in_sb      = f3_signed_b(funct3) & rs2[N-1];
        in_amag    = in_sa ? -rs1 : rs1;
        in_bmag    = in_sb ? -rs2 : rs2;
        in_div     = funct3[2];
        div0       = in_div && (rs2 == '0);
        ovf        = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (rs1 == MIN_NEG) && (rs2 == '1);
        in_special = div0 | ovf;
        if (div0)
            special_word = funct3[1] ? rs1 : '1;
        else
            special_word = funct3[1] ? '0 : MIN_NEG;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*N-1:0] fast_prod;
    assign fast_prod = {{N{1'b0}}, in_amag} * {{N{1'b0}}, in_bmag};
    assign fast_mul  = ~funct3[2];
`else
    assign fast_mul  = 1'b0;
`endif

    assign skip_calc = in_special | fast_mul;

    always_comb begin
        if (in_special)
            init_al = {special_word, {N{1'b0}}};
        else if (in_div)
            init_al = {{N{1'b0}}, in_amag};
        else
            init_al = {{N{1'b0}}, in_bmag};
`ifdef MULDIV_FAST_MUL_EN
        if (fast_mul)
            init_al = fast_prod;
`endif
    end

    assign cur_bit = op[2] ? lo[N-1] : lo[0];

    muldiv_step #(.N(N)) u_step (
        .mode    (op[2]),
        .acc     (acc),
        .lo      (lo),
        .opnd    (opnd),
        .cur_bit (cur_bit),
        .acc_nxt (step_acc),
        .lo_nxt  (step_lo),
        .qbit    (step_qbit)
    );

    // FIX: magnitudes back to signed results
    always_comb begin
        prod_s   = (sa ^ sb) ? -{acc, lo} : {acc, lo};
        mul_word = (op == F3_MUL) ? prod_s[N-1:0] : prod_s[2*N-1:N];
        quo_word = (sa ^ sb) ? -lo : lo;
        rem_word = sa ? -acc : acc;
        if (special)
            fix_word = acc;
        else if (!op[2])
            fix_word = mul_word;
        else if (op[1])
            fix_word = rem_word;
        else
            fix_word = quo_word;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = skip_calc ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op      <= '0;
            acc     <= '0;
            lo      <= '0;
            opnd    <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            special <= 1'b0;
            done_q  <= 1'b0;
            result  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    op             <= funct3;
                    sa             <= in_sa;
                    sb             <= in_sb;
                    special        <= in_special;
                    {acc, lo}      <= init_al;
                    opnd           <= in_div ? in_bmag : in_amag;
                    cnt            <= CW'(N - 1);
                end
                ST_CALC: begin
                    acc <= step_acc;
                    lo  <= {step_lo[N-1:1], step_lo[0] | step_qbit};
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    result <= fix_word;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (iterative and MULDIV_FAST_MUL_EN builds).
module tb_muldiv_unit;

    localparam int N = 32;
    localparam int DIV_LAT = N + 2;
    localparam int SPC_LAT = 2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = N + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic [N-1:0]  rs1 = '0;
    logic [N-1:0]  rs2 = '0;
    logic          busy, done;
    logic [N-1:0]  result;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Drives one start for one edge; returns #1 after the accepting edge (cycle k+1).
    task automatic issue(input logic [2:0] f3, input logic [N-1:0] a, input logic [N-1:0] b);
        start  = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        @(posedge clk); #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        rs1    = $urandom;
        rs2    = $urandom;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Entered in cycle k+j0; returns in the done cycle (or on timeout).
    task automatic wait_done(input string name, input logic [N-1:0] exp, input int lat,
                             input int j0, input bit check_pulse);
        int j = j0;
        int bb = 0;
        while (done !== 1'b1 && j < lat + 20) begin
            if (busy !== 1'b1) bb++;
            @(posedge clk); #1;
            j++;
        end
        chk({name, " latency"}, N'(j), N'(lat));
        chk({name, " result"}, result, exp);
        chk({name, " busy before done"}, N'(bb), '0);
        chk({name, " busy at done"}, N'(busy), '0);
        if (check_pulse) begin
            @(posedge clk); #1;
            chk({name, " done pulse"}, N'(done), '0);
            chk({name, " result held"}, result, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", N'(busy), '0);
        chk("reset done", N'(done), '0);
        chk("reset result", result, '0);
    endtask

    task automatic test_mul();
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done("MUL 7*-3", 32'hFFFF_FFEB, MUL_LAT, 1, 1'b1);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000);
        wait_done("MULH min*min", 32'h4000_0000, MUL_LAT, 1, 1'b1);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("MULHU", 32'hFFFF_FFFE, MUL_LAT, 1, 1'b1);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("MULHSU", 32'hFFFF_FFFF, MUL_LAT, 1, 1'b1);
    endtask

    task automatic test_div();
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        wait_done("DIV -7/2", 32'hFFFF_FFFD, DIV_LAT, 1, 1'b1);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2);
        wait_done("REM -7/2", 32'hFFFF_FFFF, DIV_LAT, 1, 1'b1);
        issue(3'b101, 32'd100, 32'd7);
        wait_done("DIVU 100/7", 32'd14, DIV_LAT, 1, 1'b1);
        issue(3'b111, 32'd100, 32'd7);
        wait_done("REMU 100/7", 32'd2, DIV_LAT, 1, 1'b1);
    endtask

    task automatic test_special();
        issue(3'b100, 32'h1234_5678, 32'd0);
        wait_done("DIV by 0", 32'hFFFF_FFFF, SPC_LAT, 1, 1'b1);
        issue(3'b110, 32'h1234_5678, 32'd0);
        wait_done("REM by 0", 32'h1234_5678, SPC_LAT, 1, 1'b1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("DIV ovf", 32'h8000_0000, SPC_LAT, 1, 1'b1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("REM ovf", 32'h0000_0000, SPC_LAT, 1, 1'b1);
    endtask

    task automatic test_start_while_busy();
        issue(3'b101, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        issue(3'b000, 32'd3, 32'd5);
        wait_done("ignored start", 32'd14, DIV_LAT, 7, 1'b1);
    endtask

    task automatic test_back_to_back();
        issue(3'b111, 32'd100, 32'd7);
        wait_done("b2b first", 32'd2, DIV_LAT, 1, 1'b0);
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done("b2b second", 32'hFFFF_FFEB, MUL_LAT, 1, 1'b1);
    endtask

    task automatic test_reset_mid_calc();
        int ndone = 0;
        issue(3'b101, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset busy", N'(busy), '0);
        chk("midreset done", N'(done), '0);
        chk("midreset result", result, '0);
        repeat (40) begin
            if (done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        chk("midreset no late done", N'(ndone), '0);
        chk("midreset result stays", result, '0);
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
